// File: rtl/counter_ctrl_if.sv
// Register bus between a host and counter_ctrl: one outstanding request, one-cycle response pulse.
// Host drives the req_* fields; the counter block returns req_ready, rsp_valid and rsp_rdata.
interface counter_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/counter_ctrl.sv
// Compare/reload counter with a register bus; response one cycle after accept, req_ready low while it is out.
// COUNTER_CTRL_PRESCALE_EN adds an 8-bit PRESC register that divides the tick rate by PRESC+1.
module counter_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    counter_ctrl_if.slave     bus,
    output logic [31:0]       count,
    output logic              irq
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] ADDR_CTRL   = 3'd0;
    localparam logic [2:0] ADDR_COUNT  = 3'd1;
    localparam logic [2:0] ADDR_CMP    = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
    localparam logic [2:0] ADDR_PRESC  = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  ctrl_q;
    logic [31:0] count_q, count_d;
    logic [31:0] cmp_q;
    logic        pend_q, pend_d;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic [31:0] rd_mux;
    logic [31:0] presc_rd;

    logic accept, wr;
    logic wr_ctrl, wr_count, wr_cmp, wr_status;
    logic tick, tick_eff, match;

    assign accept    = bus.req_valid && bus.req_ready;
    assign wr        = accept && bus.req_we;
    assign wr_ctrl   = wr && (bus.req_addr == ADDR_CTRL);
    assign wr_count  = wr && (bus.req_addr == ADDR_COUNT);
    assign wr_cmp    = wr && (bus.req_addr == ADDR_CMP);
    assign wr_status = wr && (bus.req_addr == ADDR_STATUS);

    assign bus.req_ready = !rsp_valid_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign count         = count_q;
    assign irq           = pend_q && ctrl_q[2];

`ifdef COUNTER_CTRL_PRESCALE_EN
    logic [7:0] presc_q;
    logic [7:0] presc_cnt_q;
    logic       wr_presc;

    assign wr_presc = wr && (bus.req_addr == ADDR_PRESC);
    assign tick     = (state_q == RUN) && (presc_cnt_q == presc_q);
    assign presc_rd = {24'd0, presc_q};

    // Held at zero outside RUN so every entry into RUN starts a fresh prescale period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= 8'd0;
            presc_cnt_q <= 8'd0;
        end else begin
            if (wr_presc)
                presc_q <= bus.req_wdata[7:0];
            if (state_q != RUN || wr_presc || tick)
                presc_cnt_q <= 8'd0;
            else
                presc_cnt_q <= presc_cnt_q + 8'd1;
        end
    end
`else
    assign tick     = (state_q == RUN);
    assign presc_rd = 32'd0;
`endif

    // A COUNT write swallows a coincident tick entirely, including its PEND/DONE side effects.
    assign tick_eff = tick && !wr_count;
    assign match    = (count_q == cmp_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (wr_ctrl && bus.req_wdata[0])
                    state_d = RUN;
            end
            RUN: begin
                if (wr_ctrl && !bus.req_wdata[0])
                    state_d = IDLE;
                else if (tick_eff && match && !ctrl_q[1])
                    state_d = DONE;
            end
            DONE: begin
                if (wr_ctrl)
                    state_d = bus.req_wdata[0] ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (wr_count)
            count_d = bus.req_wdata;
        else if (tick_eff) begin
            if (!match)
                count_d = count_q + 32'd1;
            else if (ctrl_q[1])
                count_d = 32'd0;
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (tick_eff && match)
            pend_d = 1'b1;
        else if (wr_status && bus.req_wdata[0])
            pend_d = 1'b0;
    end

    always_comb begin
        rd_mux = 32'd0;
        unique case (bus.req_addr)
            ADDR_CTRL:   rd_mux = {29'd0, ctrl_q};
            ADDR_COUNT:  rd_mux = count_q;
            ADDR_CMP:    rd_mux = cmp_q;
            ADDR_STATUS: rd_mux = {31'd0, pend_q};
            ADDR_PRESC:  rd_mux = presc_rd;
            default:     rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ctrl_q      <= 3'd0;
            count_q     <= 32'd0;
            cmp_q       <= 32'hFFFF_FFFF;
            pend_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            rsp_valid_q <= accept;
            rsp_rdata_q <= (accept && !bus.req_we) ? rd_mux : 32'd0;
            if (wr_ctrl)
                ctrl_q <= bus.req_wdata[2:0];
            if (wr_cmp)
                cmp_q <= bus.req_wdata;
        end
    end
endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl: register reset values, reload/one-shot modes, wrap, collisions, reset.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_counter_ctrl;
    localparam logic [2:0] A_CTRL = 3'd0, A_COUNT = 3'd1, A_CMP = 3'd2, A_STATUS = 3'd3, A_PRESC = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] count;
    logic        irq;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    counter_ctrl_if cif ();

    counter_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif),
        .count (count),
        .irq   (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata);
        int waited = 0;
        @(negedge clk);
        while (!cif.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20)
            check("ready_timeout", 32'd0, 32'd1);
        cif.req_valid = 1'b1;
        cif.req_we    = we;
        cif.req_addr  = addr;
        cif.req_wdata = wdata;
        @(posedge clk);
        #1;
        cif.req_valid = 1'b0;
        check($sformatf("rsp_valid a%0d", addr), {31'd0, cif.rsp_valid}, 32'd1);
        rdata = cif.rsp_rdata;
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wdata);
        logic [31:0] rd_unused;
        bus_xfer(1'b1, addr, wdata, rd_unused);
        check($sformatf("wr_rdata a%0d", addr), rd_unused, 32'd0);
    endtask

    task automatic rd(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        logic [31:0] rdata;
        bus_xfer(1'b0, addr, 32'd0, rdata);
        check(tag, rdata, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, cif.req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, cif.rsp_valid}, 32'd0);
        check({tag, "_rdata"}, cif.rsp_rdata, 32'd0);
        check({tag, "_count"}, count, 32'd0);
        check({tag, "_irq"}, {31'd0, irq}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wrap_seq [5];
        wrap_seq = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3};

        cif.req_valid = 1'b0;
        cif.req_we    = 1'b0;
        cif.req_addr  = 3'd0;
        cif.req_wdata = 32'd0;

        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Reset values of every index, unmapped indices read zero
        rd("rd_ctrl", A_CTRL, 32'd0);
        rd("rd_count", A_COUNT, 32'd0);
        rd("rd_cmp", A_CMP, 32'hFFFF_FFFF);
        rd("rd_status", A_STATUS, 32'd0);
        rd("rd_presc", A_PRESC, 32'd0);
        for (int a = 5; a < 8; a++)
            rd($sformatf("rd_unmapped%0d", a), 3'(a), 32'd0);
        step(1);
        check("rsp_pulse_low", {31'd0, cif.rsp_valid}, 32'd0);
        check("ready_back", {31'd0, cif.req_ready}, 32'd1);
        wr(3'd5, 32'hFFFF_FFFF);
        rd("unmapped_wr_ctrl", A_CTRL, 32'd0);
        rd("unmapped_wr_cmp", A_CMP, 32'hFFFF_FFFF);

        // Autoreload with interrupt: period CMP+1
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'd7);
        check("ar_c0", count, 32'd0);
        step(1); check("ar_c1", count, 32'd1);
        step(1); check("ar_c2", count, 32'd2);
        step(1); check("ar_c3", count, 32'd3);
        check("ar_irq_pre", {31'd0, irq}, 32'd0);
        step(1); check("ar_wrap", count, 32'd0);
        check("ar_irq", {31'd0, irq}, 32'd1);
        step(1); check("ar_c1b", count, 32'd1);
        wr(A_STATUS, 32'd1);
        check("ar_clr_count", count, 32'd2);
        check("ar_clr_irq", {31'd0, irq}, 32'd0);
        step(1); check("ar_irq_low", {31'd0, irq}, 32'd0);
        step(1); check("ar_irq2", {31'd0, irq}, 32'd1);
        check("ar_wrap2", count, 32'd0);
        wr(A_CTRL, 32'd0);
        check("stop_count", count, 32'd1);
        step(2); check("idle_hold", count, 32'd1);
        wr(A_STATUS, 32'd1);
        rd("status_clr", A_STATUS, 32'd0);

        // One-shot: stop at CMP in DONE, restart from DONE keeps count
        wr(A_COUNT, 32'd0);
        wr(A_CMP, 32'd5);
        wr(A_CTRL, 32'd1);
        check("os_c0", count, 32'd0);
        step(5); check("os_c5", count, 32'd5);
        step(5); check("os_hold", count, 32'd5);
        check("os_irq_masked", {31'd0, irq}, 32'd0);
        rd("os_pend", A_STATUS, 32'd1);
        wr(A_STATUS, 32'd1);
        rd("os_pend_clr", A_STATUS, 32'd0);
        wr(A_CTRL, 32'd5);
        check("os_restart_count", count, 32'd5);
        check("os_restart_irq", {31'd0, irq}, 32'd0);
        step(1);
        check("os_rematch_count", count, 32'd5);
        check("os_rematch_irq", {31'd0, irq}, 32'd1);
        step(3); check("os_done_hold", count, 32'd5);
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);

        // 32-bit wrap without a spurious match
        wr(A_COUNT, 32'hFFFF_FFFE);
        wr(A_CMP, 32'd3);
        wr(A_CTRL, 32'd5);
        check("wr_start", count, 32'hFFFF_FFFE);
        for (int i = 0; i < 5; i++) begin
            step(1);
            check($sformatf("wrap_c%0d", i), count, wrap_seq[i]);
            check($sformatf("wrap_irq%0d", i), {31'd0, irq}, 32'd0);
        end
        step(1);
        check("wrap_match_count", count, 32'd3);
        check("wrap_match_irq", {31'd0, irq}, 32'd1);
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);

        // COUNT write beats a tick; PEND set beats a clear
        wr(A_CMP, 32'd100);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'd1);
        step(2); check("col_pre", count, 32'd2);
        wr(A_COUNT, 32'h10);
        check("col_count_wr", count, 32'h10);
        step(1); check("col_count_next", count, 32'h11);
        wr(A_CTRL, 32'd0);
        wr(A_CMP, 32'd3);
        wr(A_COUNT, 32'd0);
        wr(A_STATUS, 32'd1);
        wr(A_CTRL, 32'd7);
        step(3); check("col_pre_match", count, 32'd3);
        wr(A_STATUS, 32'd1);
        check("col_match_count", count, 32'd0);
        check("col_set_wins", {31'd0, irq}, 32'd1);
        wr(A_STATUS, 32'd1);
        check("col_later_clr", {31'd0, irq}, 32'd0);
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);

        // Tick rate with and without the prescaler
        wr(A_CMP, 32'd1000);
        wr(A_COUNT, 32'd0);
`ifdef COUNTER_CTRL_PRESCALE_EN
        wr(A_PRESC, 32'h1FF);
        rd("presc_mask", A_PRESC, 32'hFF);
        wr(A_PRESC, 32'd2);
        rd("presc_rd", A_PRESC, 32'd2);
        wr(A_CTRL, 32'd1);
        check("ps_c0", count, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            step(1);
            check($sformatf("ps_step%0d", i), count, 32'(i / 3));
        end
`else
        wr(A_PRESC, 32'd2);
        rd("presc_ignored", A_PRESC, 32'd0);
        wr(A_CTRL, 32'd1);
        check("ps_c0", count, 32'd0);
        for (int i = 1; i <= 9; i++) begin
            step(1);
            check($sformatf("ps_step%0d", i), count, 32'(i));
        end
`endif
        wr(A_CTRL, 32'd0);
        wr(A_STATUS, 32'd1);

        // Asynchronous reset with a response in flight
        wr(A_CMP, 32'd2);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'd7);
        step(4);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        cif.req_valid = 1'b1;
        cif.req_we    = 1'b0;
        cif.req_addr  = A_COUNT;
        @(posedge clk);
        #1;
        cif.req_valid = 1'b0;
        check("inflight_valid", {31'd0, cif.rsp_valid}, 32'd1);
        check("inflight_rdata", cif.rsp_rdata, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("no_stale_rsp", {31'd0, cif.rsp_valid}, 32'd0);
        check("post_rst_count", count, 32'd0);

        // First edge after release accepts a request
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        cif.req_valid = 1'b1;
        cif.req_we    = 1'b0;
        cif.req_addr  = A_CMP;
        @(posedge clk);
        #1;
        cif.req_valid = 1'b0;
        check("first_accept_valid", {31'd0, cif.rsp_valid}, 32'd1);
        check("first_accept_cmp", cif.rsp_rdata, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
